elbeth_muldiv: RTL and testbench

ELBETH_MULDIV -- requirements
Module: elbeth_muldiv

---
 rtl/elbeth_pkg.sv | 25 ++
 rtl/elbeth_muldiv.sv | 120 ++++++++++++
 tb/tb_elbeth_muldiv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/elbeth_pkg.sv
// Shared definitions for the elbeth multiply/divide unit: operation codes
// and the FSM state encoding.
package elbeth_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/elbeth_muldiv.sv
// Iterative 32x32 multiply / 32/32 divide on one shared 33-bit adder.
// Operands are reduced to magnitudes on accept; the sign is restored in FIX.
module elbeth_muldiv
    import elbeth_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        operation,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_zero,
    output state_t            state_dbg
);

    // Handshake: start is a one-way request honoured only in IDLE (no queueing,
    // no backpressure); busy covers CALC/FIX/DONE and done pulses for one cycle.
    state_t            state, state_nxt;
    logic [4:0]        count;
    logic              load_pend;
    logic [1:0]        op_q;
    logic              neg_a, neg_b, b_zero;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W-1:0] p_hi, p_lo;
    logic              accept, op_div;
    logic [DATA_W:0]   shifted, add_x, add_y, sum;
    logic [2*DATA_W-1:0] prod;

    assign state_dbg = state;
    assign accept    = (state == ST_IDLE) && start;
    assign op_div    = op_is_div(op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (!load_pend && count == 5'd31) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shared adder: multiply adds the multiplicand when the multiplier LSB is
    // set; divide subtracts the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {p_hi, p_lo[DATA_W-1]};
        add_x   = op_div ? shifted : {1'b0, p_hi};
        add_y   = op_div ? ~{1'b0, mag_b}
                         : (p_lo[0] ? {1'b0, mag_a} : '0);
        sum     = add_x + add_y + {{DATA_W{1'b0}}, op_div};
        prod    = {p_hi, p_lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            load_pend <= 1'b0;
            op_q      <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            b_zero    <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            op_q      <= operation;
            neg_a     <= op_is_signed(operation) & data_a[DATA_W-1];
            neg_b     <= op_is_signed(operation) & data_b[DATA_W-1];
            mag_a     <= (op_is_signed(operation) & data_a[DATA_W-1]) ? -data_a : data_a;
            mag_b     <= (op_is_signed(operation) & data_b[DATA_W-1]) ? -data_b : data_b;
            b_zero    <= op_is_div(operation) && (data_b == '0);
            div_zero  <= 1'b0;
            count     <= '0;
            load_pend <= 1'b1;
        end else if (state == ST_CALC) begin
            if (load_pend) begin
                // First CALC cycle seeds the shift register from the magnitudes.
                p_hi      <= '0;
                p_lo      <= op_div ? mag_a : mag_b;
                load_pend <= 1'b0;
            end else begin
                count <= count + 5'd1;
                if (op_div) begin
                    p_hi <= sum[DATA_W] ? shifted[DATA_W-1:0] : sum[DATA_W-1:0];
                    p_lo <= {p_lo[DATA_W-2:0], ~sum[DATA_W]};
                end else begin
                    p_hi <= sum[DATA_W:1];
                    p_lo <= {sum[0], p_lo[DATA_W-1:1]};
                end
            end
        end else if (state == ST_FIX) begin
            if (!op_div) begin
                {hi, lo} <= (neg_a ^ neg_b) ? -prod : prod;
            end else begin
                hi       <= neg_a ? -p_hi : p_hi;
                lo       <= b_zero ? '1 : ((neg_a ^ neg_b) ? -p_lo : p_lo);
                div_zero <= b_zero;
            end
        end
    end

endmodule

// File: tb/tb_elbeth_muldiv.sv
// Directed bench for elbeth_muldiv: hand-computed multiply/divide vectors,
// latency, ignored mid-run start, and asynchronous abort.
module tb_elbeth_muldiv;
    import elbeth_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  operation;
    logic [31:0] data_a, data_b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    state_t      state_dbg;

    int tests  = 0;
    int failed = 0;

    elbeth_muldiv #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operation (operation),
        .data_a    (data_a),
        .data_b    (data_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the edge
    // that brings the DUT back to IDLE. lat = edges from accept to done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        start = 1'b1; operation = op; data_a = a; data_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        data_a = $urandom; data_b = $urandom;
        operation = 2'($urandom_range(0, 3));
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    int lat;
    int done_cnt;
    int busy_after_rst;

    initial begin
        rst_n = 1'b0; start = 1'b0; operation = '0; data_a = '0; data_b = '0;
        #12;
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_div_zero", {63'd0, div_zero}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_max_lat", 64'(lat), 64'd34);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        check("idle_after_done", {63'd0, busy}, 64'd0);

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd4, lat);
        check("mult_neg3x4", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);

        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, lat);
        check("mult_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, lat);
        check("div_7_neg2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        run_op(MD_DIVU, 32'd7, 32'd2, lat);
        check("divu_7_2", {hi, lo}, 64'h0000_0001_0000_0003);

        run_op(MD_DIVU, 32'd5, 32'd0, lat);
        check("divu_zero_lat", 64'(lat), 64'd34);
        check("divu_zero", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        check("divu_zero_flag", {63'd0, div_zero}, 64'd1);

        run_op(MD_MULTU, 32'd3, 32'd4, lat);
        check("multu_3x4", {hi, lo}, 64'h0000_0000_0000_000C);
        check("div_zero_cleared", {63'd0, div_zero}, 64'd0);

        run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0, lat);
        check("div_neg5_zero", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
        check("div_neg5_zero_flag", {63'd0, div_zero}, 64'd1);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div_overflow_flag", {63'd0, div_zero}, 64'd0);

        // Second start during CALC must be ignored; operands may change freely.
        start = 1'b1; operation = MD_DIVU; data_a = 32'd100; data_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("hold_prev_during_busy", {hi, lo}, 64'h0000_0000_8000_0000);
        start = 1'b1; operation = MD_MULT; data_a = 32'd999; data_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; data_a = 32'd12345;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("midrun_start_result", {hi, lo}, 64'h0000_0002_0000_000E);
        check("midrun_done_count", 64'(done_cnt), 64'd1);

        // Asynchronous abort in the middle of CALC.
        start = 1'b1; operation = MD_MULTU; data_a = 32'd3; data_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
        end
        check("busy_before_abort", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        done_cnt = 0;
        busy_after_rst = 0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (busy) busy_after_rst++;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (busy) busy_after_rst++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_stays_idle", 64'(busy_after_rst), 64'd0);

        run_op(MD_MULTU, 32'd6, 32'd7, lat);
        check("post_abort_lat", 64'(lat), 64'd34);
        check("post_abort_result", {hi, lo}, 64'h0000_0000_0000_002A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
